// File: rtl/hdd_sector_server.sv
// hdd_sector_server: moves one 512-byte sector between the HDD controller buffer and storage.
// Optional watchdog abort when HDD_SECTOR_SERVER_TIMEOUT_EN is defined.
module hdd_sector_server #(
  parameter logic [31:0] LBA_BASE       = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] hdd_sector,
  input  logic        hdd_read,
  input  logic        hdd_write,
  output logic [8:0]  ram_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  input  logic [7:0]  ram_do,
  output logic [31:0] st_lba,
  output logic        st_rd,
  output logic        st_wr,
  input  logic        st_ack,
  input  logic [7:0]  st_rdata,
  input  logic        st_rvalid,
  output logic [7:0]  st_wdata,
  output logic        st_wvalid,
  input  logic        st_wready,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, CMD, RDATA, WPRE, WFETCH, WDATA, FIN} state_t;
  state_t state, state_nxt;
  logic rd_q, wr_q, dir_wr, tout, rd_edge, wr_edge;
  logic [9:0] cnt;
  logic [7:0] wdata_q;
  assign rd_edge = hdd_read & ~rd_q;
  assign wr_edge = hdd_write & ~wr_q;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_edge | wr_edge) state_nxt = CMD;
      CMD:     if (st_ack) state_nxt = dir_wr ? WPRE : RDATA;
      RDATA:   if (st_rvalid && cnt == 10'd511) state_nxt = FIN;
      WPRE:    state_nxt = WFETCH;
      WFETCH:  state_nxt = WDATA;
      WDATA:   if (st_wready) state_nxt = (cnt == 10'd511) ? FIN : WFETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tout) state_nxt = FIN;
  end
  // An accepted write byte already presents the next address so the buffer read overlaps the fetch cycle
  always_comb begin
    busy      = (state != IDLE) && (state != FIN);
    done      = state == FIN;
    st_rd     = (state == CMD) && !dir_wr;
    st_wr     = (state == CMD) && dir_wr;
    ram_we    = (state == RDATA) && st_rvalid;
    ram_di    = (state == RDATA) ? st_rdata : 8'h00;
    ram_addr  = (state == WDATA && st_wready) ? cnt[8:0] + 9'd1 : cnt[8:0];
    st_wvalid = state == WDATA;
  end
  assign st_wdata = wdata_q;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dir_wr  <= 1'b0;
      st_lba  <= '0;
      cnt     <= '0;
      wdata_q <= '0;
    end else begin
      rd_q <= hdd_read;
      wr_q <= hdd_write;
      if (state == IDLE && (rd_edge | wr_edge)) begin
        dir_wr <= ~rd_edge;
        st_lba <= LBA_BASE + {16'h0, hdd_sector};
      end
      if (state == CMD) cnt <= '0;
      else if ((state == RDATA && st_rvalid) || (state == WDATA && st_wready)) cnt <= cnt + 10'd1;
      if (state == WFETCH) wdata_q <= ram_do;
    end
`ifdef HDD_SECTOR_SERVER_TIMEOUT_EN
  logic [31:0] wdog;
  logic abort_q, err_q;
  assign tout  = busy && (wdog >= TIMEOUT_CYCLES) && !(st_ack || st_rvalid || st_wready);
  assign error = err_q;
  // abort_q marks the FIN entered by a timeout so that FIN keeps error set
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wdog    <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wdog    <= ((state == IDLE && (rd_edge | wr_edge)) || st_ack || st_rvalid || st_wready) ? 32'd0 :
                 busy ? wdog + 32'd1 : wdog;
      abort_q <= tout;
      err_q   <= tout ? 1'b1 : (done && !abort_q) ? 1'b0 : err_q;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tout  = 1'b0;
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_hdd_sector_server.sv
// tb_hdd_sector_server: directed sector read/write scenarios checked against a byte scoreboard.
module tb_hdd_sector_server;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] hdd_sector = '0;
  logic hdd_read = 1'b0, hdd_write = 1'b0;
  logic [8:0] ram_addr;
  logic [7:0] ram_di, ram_do;
  logic ram_we;
  logic [31:0] st_lba;
  logic st_rd, st_wr;
  logic st_ack = 1'b0;
  logic [7:0] st_rdata = '0;
  logic st_rvalid = 1'b0;
  logic [7:0] st_wdata;
  logic st_wvalid;
  logic st_wready = 1'b0;
  logic busy, done, error;
  logic [8:0] w_ram_addr;
  logic [7:0] w_ram_di, w_st_wdata;
  logic w_ram_we, w_st_rd, w_st_wr, w_st_wvalid, w_busy, w_done, w_error;
  logic [31:0] w_st_lba;
  logic [7:0] mem [512];
  logic preload = 1'b0;
  logic [16:0] exp_q [$];
  logic [7:0] wq [$];
  int errors = 0, checks = 0, we_cnt = 0, done_cnt = 0, acc_cnt = 0;
  bit rd_seen, wr_seen, hold_pend;
  logic [7:0] hold_val;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (preload) for (int i = 0; i < 512; i++) mem[i] <= 8'(i);
    else if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  hdd_sector_server #(.LBA_BASE(32'h0000_0100), .TIMEOUT_CYCLES(100)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hdd_sector(hdd_sector), .hdd_read(hdd_read),
    .hdd_write(hdd_write), .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do),
    .st_lba(st_lba), .st_rd(st_rd), .st_wr(st_wr), .st_ack(st_ack), .st_rdata(st_rdata),
    .st_rvalid(st_rvalid), .st_wdata(st_wdata), .st_wvalid(st_wvalid), .st_wready(st_wready),
    .busy(busy), .done(done), .error(error)
  );

  // Same stimulus with a base that forces the LBA sum to wrap
  hdd_sector_server #(.LBA_BASE(32'hFFFF_0001), .TIMEOUT_CYCLES(100)) u_wrap (
    .clk_sys(clk_sys), .reset_n(reset_n), .hdd_sector(hdd_sector), .hdd_read(hdd_read),
    .hdd_write(hdd_write), .ram_addr(w_ram_addr), .ram_di(w_ram_di), .ram_we(w_ram_we), .ram_do(ram_do),
    .st_lba(w_st_lba), .st_rd(w_st_rd), .st_wr(w_st_wr), .st_ack(st_ack), .st_rdata(st_rdata),
    .st_rvalid(st_rvalid), .st_wdata(w_st_wdata), .st_wvalid(w_st_wvalid), .st_wready(st_wready),
    .busy(w_busy), .done(w_done), .error(w_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {st_lba, ram_addr, ram_di, st_wdata, busy, done, error, st_rd, st_wr, st_wvalid, ram_we};
  endfunction

  task automatic clear();
    we_cnt = 0; done_cnt = 0; acc_cnt = 0;
    rd_seen = 0; wr_seen = 0; hold_pend = 0;
  endtask

  // One clock: observe on the falling edge, then return just after the rising edge
  task automatic tick();
    logic [16:0] e;
    @(negedge clk_sys);
    if (ram_we) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("we_sb_depth", 64'(exp_q.size()), 64'(1));
      else begin
        e = exp_q.pop_front();
        chk("we_addr", 64'(ram_addr), 64'(e[16:8]));
        chk("we_data", 64'(ram_di), 64'(e[7:0]));
      end
    end
    if (done) done_cnt++;
    if (st_rd) rd_seen = 1;
    if (st_wr) wr_seen = 1;
    if (hold_pend) begin
      chk("wvalid_hold", 64'(st_wvalid), 64'(1));
      chk("wdata_hold", 64'(st_wdata), 64'(hold_val));
    end
    if (st_wvalid && st_wready) begin
      acc_cnt++;
      if (wq.size() == 0) chk("acc_sb_depth", 64'(wq.size()), 64'(1));
      else chk("wdata", 64'(st_wdata), 64'(wq.pop_front()));
    end
    hold_pend = st_wvalid && !st_wready;
    hold_val = st_wdata;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ack_cmd();
    int n = 0;
    while (!(st_rd || st_wr) && n < 20) begin tick(); n++; end
    chk("cmd_wait", 64'(st_rd || st_wr), 64'(1));
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      st_rvalid = 1'b1;
      st_rdata = 8'(i) ^ 8'h5A;
      exp_q.push_back({9'(i), st_rdata});
      tick();
      st_rvalid = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n, bl, eh;
    #12;
    chk("reset_outputs", outs(), 64'(0));
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    tick();
    // Read sector 0x12
    clear();
    hdd_sector = 16'h0012; hdd_read = 1'b1;
    tick();
    hdd_read = 1'b0;
    chk("rd_start", 64'(st_rd), 64'(1));
    chk("rd_no_wr", 64'(st_wr), 64'(0));
    chk("rd_busy", 64'(busy), 64'(1));
    chk("rd_lba", 64'(st_lba), 64'h112);
    chk("rd_lba_wrapinst", 64'(w_st_lba), 64'hFFFF_0013);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rd_hold", 64'(st_rd), 64'(1));
      chk("rd_lba_stable", 64'(st_lba), 64'h112);
    end
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
    chk("rd_drop", 64'(st_rd), 64'(0));
    stream(512);
    st_rvalid = 1'b1; st_rdata = 8'hEE;
    tick(); tick();
    st_rvalid = 1'b0;
    repeat (4) tick();
    chk("rd_we_count", 64'(we_cnt), 64'(512));
    chk("rd_done_count", 64'(done_cnt), 64'(1));
    chk("rd_sb_left", 64'(exp_q.size()), 64'(0));
    chk("rd_busy_end", 64'(busy), 64'(0));
    chk("rd_error", 64'(error), 64'(0));
    chk("rd_no_wr_seen", 64'(wr_seen), 64'(0));
    // Write sector 0xFFFF with random backpressure
    clear();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int i = 0; i < 512; i++) wq.push_back(8'(i));
    hdd_sector = 16'hFFFF; hdd_write = 1'b1;
    tick();
    hdd_write = 1'b0;
    chk("wr_start", 64'(st_wr), 64'(1));
    chk("wr_no_rd", 64'(st_rd), 64'(0));
    chk("wr_lba", 64'(st_lba), 64'h100FF);
    chk("wr_lba_wrap", 64'(w_st_lba), 64'(0));
    ack_cmd();
    n = 0;
    while (done_cnt == 0 && n < 8000) begin
      st_wready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    st_wready = 1'b0;
    repeat (3) tick();
    chk("wr_accept_count", 64'(acc_cnt), 64'(512));
    chk("wr_sb_left", 64'(wq.size()), 64'(0));
    chk("wr_done_count", 64'(done_cnt), 64'(1));
    chk("wr_no_ram_we", 64'(we_cnt), 64'(0));
    chk("wr_no_rd_seen", 64'(rd_seen), 64'(0));
    chk("wr_busy_end", 64'(busy), 64'(0));
    // Simultaneous edges: read wins, later edges and held levels ignored
    clear();
    hdd_sector = 16'h0001; hdd_read = 1'b1; hdd_write = 1'b1;
    tick();
    chk("sim_rd", 64'(st_rd), 64'(1));
    chk("sim_wr", 64'(st_wr), 64'(0));
    ack_cmd();
    hdd_write = 1'b0;
    tick();
    hdd_write = 1'b1;
    stream(512);
    repeat (20) tick();
    chk("sim_done_count", 64'(done_cnt), 64'(1));
    chk("sim_no_wr_seen", 64'(wr_seen), 64'(0));
    chk("sim_busy_end", 64'(busy), 64'(0));
    chk("sim_we_count", 64'(we_cnt), 64'(512));
    hdd_read = 1'b0; hdd_write = 1'b0;
    tick();
    // Asynchronous reset at byte 200 of a read
    clear();
    hdd_sector = 16'h0003; hdd_read = 1'b1;
    tick();
    hdd_read = 1'b0;
    ack_cmd();
    stream(200);
    st_rvalid = 1'b1; st_rdata = 8'd200 ^ 8'h5A;
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_outputs", outs(), 64'(0));
    st_rvalid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("reset_no_done", 64'(done_cnt), 64'(0));
    chk("reset_we_count", 64'(we_cnt), 64'(200));
    chk("reset_sb_left", 64'(exp_q.size()), 64'(0));
    clear();
    hdd_read = 1'b1;
    tick();
    hdd_read = 1'b0;
    ack_cmd();
    stream(512);
    repeat (4) tick();
    chk("restart_we_count", 64'(we_cnt), 64'(512));
    chk("restart_done_count", 64'(done_cnt), 64'(1));
    // Backend stalls after byte 10
    clear();
    hdd_read = 1'b1;
    tick();
    hdd_read = 1'b0;
    ack_cmd();
    stream(11);
`ifdef HDD_SECTOR_SERVER_TIMEOUT_EN
    n = 0;
    while (done_cnt == 0 && n < 400) begin tick(); n++; end
    chk("to_done", 64'(done_cnt), 64'(1));
    chk("to_window", 64'(n >= 80 && n <= 120), 64'(1));
    chk("to_error", 64'(error), 64'(1));
    chk("to_busy", 64'(busy), 64'(0));
    repeat (3) tick();
    chk("to_error_sticky", 64'(error), 64'(1));
    chk("to_we_count", 64'(we_cnt), 64'(11));
`else
    bl = 0; eh = 0;
    repeat (1000) begin
      tick();
      if (!busy) bl++;
      if (error) eh++;
    end
    chk("stall_busy_low", 64'(bl), 64'(0));
    chk("stall_error_high", 64'(eh), 64'(0));
    chk("stall_no_done", 64'(done_cnt), 64'(0));
    chk("stall_we_count", 64'(we_cnt), 64'(11));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hdd_sector_server.md
Name: hdd_sector_server

Overview:
- Host-side responder for the slot-7 hard-disk controller's sector-request interface.
- Detects a controller read or write request for a 512-byte sector. Handshakes the offset LBA to the storage backend, then moves 512 bytes between the backend byte stream and the controller's sector buffer.
- The buffer is reached through its ram_addr/ram_di/ram_we/ram_do port.
- Sits in the system top beside the iigs core and serves the HDD_* signals.

Parameters:
- LBA_BASE, 0: 32-bit offset added to the controller's 16-bit sector number.
- TIMEOUT_CYCLES, 2000000: watchdog limit in clk_sys cycles; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hdd_sector  in  16  sector number from the controller.
- hdd_read  in  1  controller read request, level.
- hdd_write  in  1  controller write request, level.
- ram_addr  out  9  sector-buffer byte address.
- ram_di  out  8  byte written into the sector buffer.
- ram_we  out  1  sector-buffer write strobe.
- ram_do  in  8  sector-buffer read data, valid 1 cycle after ram_addr.
- st_lba  out  32  LBA presented to storage.
- st_rd  out  1  storage read command.
- st_wr  out  1  storage write command.
- st_ack  in  1  storage accepts command.
- st_rdata  in  8  read byte from storage.
- st_rvalid  in  1  st_rdata valid this cycle.
- st_wdata  out  8  write byte to storage.
- st_wvalid  out  1  st_wdata valid.
- st_wready  in  1  storage consumes st_wdata this cycle.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- error  out  1  sticky: last transfer aborted.

Behaviour:
- Reset (async, reset_n=0): every output low/zero. State IDLE, byte counter 0, request edge registers cleared.
- Request detection: hdd_read and hdd_write are registered once. A request is a rising edge of either.
  - Both rise in the same cycle: read wins; the write edge is dropped.
  - Edges are ignored outside IDLE.
  - A request level held across a completed transfer does not re-trigger; a new rising edge is required.
- IDLE -> CMD on request edge.
  - Latch st_lba = LBA_BASE + zero-extended hdd_sector, modulo 2^32.
  - Latch direction.
  - busy=1 from the next cycle.
- CMD:
  - Hold st_rd or st_wr high with st_lba stable until the cycle st_ack=1.
  - Then drop the command and go to RDATA (read) or WPRE (write).
  - Byte counter = 0.
- RDATA (read path):
  - Each cycle with st_rvalid=1: ram_addr=counter, ram_di=st_rdata, ram_we=1 for exactly that cycle, counter+1.
  - st_rvalid=0: ram_we=0, no advance.
  - After byte 511 is written, go to FIN.
  - st_rvalid after the 512th byte is ignored.
- WPRE (write path, buffer prefetch):
  - Drive ram_addr=0; next cycle capture ram_do into the output register.
  - Then st_wvalid=1 with st_wdata=byte 0; go to WDATA.
- WDATA:
  - On each st_wvalid & st_wready cycle, counter+1.
  - ram_addr is driven to counter+1 in the same cycle, so the next byte's data is captured one cycle later.
  - st_wvalid is deasserted for exactly that fetch cycle, giving 2 cycles per byte minimum.
  - st_wdata stays stable while st_wvalid=1 and st_wready=0.
  - After byte 511 is accepted: st_wvalid=0, go to FIN.
  - ram_we is never asserted on the write path.
- FIN:
  - done=1 for one cycle, busy=0, error cleared.
  - Return to IDLE.
- Counter width is 10 bits internally; ram_addr = counter[8:0]; terminal count is 512.
- Reset mid-transfer: immediate abort. No done pulse. Storage command dropped asynchronously.

Optional Feature:
- Macro HDD_SECTOR_SERVER_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog clears on entering CMD and on every st_ack, st_rvalid or st_wready cycle.
  - Otherwise it increments while busy.
  - On reaching TIMEOUT_CYCLES: drop st_rd/st_wr/st_wvalid/ram_we, set error=1, pulse done, return to IDLE.
  - Buffer contents are left partially written.
- Undefined:
  - No watchdog; a stalled backend holds busy indefinitely.
  - error stays 0.

Test Plan:
- Read: hdd_sector=0x0012, LBA_BASE=0x100, pulse hdd_read; st_ack after 3 cycles; stream bytes i^0x5A with st_rvalid every other cycle -> st_lba=0x112, st_rd high until ack, 512 ram_we pulses at addresses 0..511 carrying i^0x5A, one done pulse, busy low after.
- Write: buffer preloaded with byte i = i[7:0]; hdd_write edge with sector 0xFFFF, LBA_BASE=0xFFFF0001; st_wready toggled randomly -> st_lba=0x00000000 (wrap), exactly 512 accepted bytes equal to 0..255,0..255 in order, st_wdata stable under backpressure, ram_we never high.
- Simultaneous hdd_read and hdd_write rising edges -> read transfer only (st_rd asserted, st_wr never asserted); further edges during busy are ignored, and hdd_read held high afterward does not start a second transfer.
- Async reset asserted at byte 200 of a read -> all outputs 0 in the same cycle, no done pulse; a fresh hdd_read edge afterward restarts at ram_addr 0.
- Timeout (macro defined, TIMEOUT_CYCLES=100): st_ack given, st_rvalid then withheld after byte 10 -> after 100 idle cycles error=1, done pulse, IDLE. Without the macro: busy stays 1 for 1000 cycles and error stays 0.
